execute_stage: RTL and testbench

//  Execute slice of the 5-stage 16-bit pipelined CPU: Decode/Execute pipeline register, ALU,

---
 rtl/execute_stage.sv | 138 +++++++++++++
 tb/tb_execute_stage.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Execute slice of the 16-bit pipelined CPU: D/E register, ALU, address/data split,
// and E/M register. E-stage flags and exe_value are combinational off the D/E register.
module execute_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        wbs_in,
  input  logic        mm_in,
  input  logic [2:0]  ALUop_in,
  input  logic        wm_in,
  input  logic        ni_in,
  input  logic        wme_in,
  input  logic        am_in,
  input  logic        alu_mux_in,
  input  logic        alu_mux1_in,
  input  logic [3:0]  reg_dest_in,
  input  logic [15:0] srcA_in,
  input  logic [15:0] srcB_in,
  output logic [15:0] srcB_execute,
  output logic        flagN,
  output logic        flagZ,
  output logic [15:0] exe_value,
  output logic        wbs_out,
  output logic        mm_out,
  output logic        wm_out,
  output logic        ni_out,
  output logic        wme_out,
  output logic [3:0]  reg_dest_out,
  output logic [15:0] alu_result_out,
  output logic [15:0] mem_data_out
);

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SHL  = 3'b101,
    ALU_SHR  = 3'b110,
    ALU_PASS = 3'b111
  } aluOp_e;

  logic        r_wbs;
  logic        r_mm;
  aluOp_e      r_aluOp;
  logic        r_wm;
  logic        r_ni;
  logic        r_wme;
  logic        r_am;
  logic        r_aluMux;
  logic        r_aluMux1;
  logic [3:0]  r_regDest;
  logic [15:0] r_srcA;
  logic [15:0] r_srcB;

  logic [15:0] w_aluResult;
  logic [15:0] w_readAddr;
  logic [15:0] w_writeData;
  logic [15:0] w_fwd;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wbs     <= 1'b0;
      r_mm      <= 1'b0;
      r_aluOp   <= ALU_ADD;
      r_wm      <= 1'b0;
      r_ni      <= 1'b0;
      r_wme     <= 1'b0;
      r_am      <= 1'b0;
      r_aluMux  <= 1'b0;
      r_aluMux1 <= 1'b0;
      r_regDest <= 4'h0;
      r_srcA    <= 16'h0000;
      r_srcB    <= 16'h0000;
    end else begin
      r_wbs     <= wbs_in;
      r_mm      <= mm_in;
      r_aluOp   <= aluOp_e'(ALUop_in);
      r_wm      <= wm_in;
      r_ni      <= ni_in;
      r_wme     <= wme_in;
      r_am      <= am_in;
      r_aluMux  <= alu_mux_in;
      r_aluMux1 <= alu_mux1_in;
      r_regDest <= reg_dest_in;
      r_srcA    <= srcA_in;
      r_srcB    <= srcB_in;
    end
  end

  // Arithmetic wraps mod 2^16; only B[3:0] is used as a shift amount.
  always_comb begin
    w_aluResult = 16'h0000;
    unique case (r_aluOp)
      ALU_ADD:  w_aluResult = r_srcA + r_srcB;
      ALU_SUB:  w_aluResult = r_srcA - r_srcB;
      ALU_AND:  w_aluResult = r_srcA & r_srcB;
      ALU_OR:   w_aluResult = r_srcA | r_srcB;
      ALU_XOR:  w_aluResult = r_srcA ^ r_srcB;
      ALU_SHL:  w_aluResult = r_srcA << r_srcB[3:0];
      ALU_SHR:  w_aluResult = r_srcA >> r_srcB[3:0];
      ALU_PASS: w_aluResult = r_srcB;
      default:  w_aluResult = 16'h0000;
    endcase
  end

  assign flagN        = w_aluResult[15];
  assign flagZ        = (w_aluResult == 16'h0000);
  assign srcB_execute = r_srcB;

  assign w_readAddr  = r_am ? 16'h0000 : r_srcB;
  assign w_writeData = r_am ? r_srcB : 16'h0000;
  assign w_fwd       = r_aluMux ? w_readAddr : w_aluResult;
  assign exe_value   = r_aluMux1 ? w_fwd : r_srcA;

  always_ff @(posedge clk) begin
    if (reset) begin
      wbs_out        <= 1'b0;
      mm_out         <= 1'b0;
      wm_out         <= 1'b0;
      ni_out         <= 1'b0;
      wme_out        <= 1'b0;
      reg_dest_out   <= 4'h0;
      alu_result_out <= 16'h0000;
      mem_data_out   <= 16'h0000;
    end else begin
      wbs_out        <= r_wbs;
      mm_out         <= r_mm;
      wm_out         <= r_wm;
      ni_out         <= r_ni;
      wme_out        <= r_wme;
      reg_dest_out   <= r_regDest;
      alu_result_out <= w_fwd;
      mem_data_out   <= w_writeData;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: stimulus queues expected E- and M-stage values,
// a negedge monitor pops and compares them when the matching clock edge has passed.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        wbs_in, mm_in, wm_in, ni_in, wme_in;
  logic [2:0]  ALUop_in;
  logic        am_in, alu_mux_in, alu_mux1_in;
  logic [3:0]  reg_dest_in;
  logic [15:0] srcA_in, srcB_in;
  logic [15:0] srcB_execute;
  logic        flagN, flagZ;
  logic [15:0] exe_value;
  logic        wbs_out, mm_out, wm_out, ni_out, wme_out;
  logic [3:0]  reg_dest_out;
  logic [15:0] alu_result_out, mem_data_out;

  typedef struct {
    int          edgeNo;
    logic [15:0] srcB;
    logic [15:0] exeValue;
    logic        flagN;
    logic        flagZ;
  } eExp_t;

  typedef struct {
    int          edgeNo;
    logic [15:0] result;
    logic [15:0] memData;
    logic [3:0]  regDest;
    logic [4:0]  ctl;
  } mExp_t;

  eExp_t eQ[$];
  mExp_t mQ[$];
  int    edgeCount  = 0;
  int    checkCount = 0;
  int    failCount  = 0;

  execute_stage dut (
    .clk(clk), .reset(reset),
    .wbs_in(wbs_in), .mm_in(mm_in), .ALUop_in(ALUop_in),
    .wm_in(wm_in), .ni_in(ni_in), .wme_in(wme_in),
    .am_in(am_in), .alu_mux_in(alu_mux_in), .alu_mux1_in(alu_mux1_in),
    .reg_dest_in(reg_dest_in), .srcA_in(srcA_in), .srcB_in(srcB_in),
    .srcB_execute(srcB_execute), .flagN(flagN), .flagZ(flagZ), .exe_value(exe_value),
    .wbs_out(wbs_out), .mm_out(mm_out), .wm_out(wm_out), .ni_out(ni_out),
    .wme_out(wme_out), .reg_dest_out(reg_dest_out),
    .alu_result_out(alu_result_out), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgeCount <= edgeCount + 1;

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at edge %0d: got %h, expected %h", name, edgeCount, actual, expected);
    end
  endtask

  // Drives one cycle of inputs; a reset cycle expects zeros in both stages.
  task automatic applyStimulus(input logic rst, input logic [2:0] op,
                               input logic [15:0] a, input logic [15:0] b,
                               input logic am, input logic aluMux, input logic aluMux1,
                               input logic [3:0] rd, input logic [4:0] ctl,
                               input logic [15:0] expRes, input logic [15:0] expMem,
                               input logic [15:0] expExe, input logic expN, input logic expZ);
    eExp_t e;
    mExp_t m;
    int    sampleEdge;
    @(negedge clk);
    reset       = rst;
    ALUop_in    = op;
    srcA_in     = a;
    srcB_in     = b;
    am_in       = am;
    alu_mux_in  = aluMux;
    alu_mux1_in = aluMux1;
    reg_dest_in = rd;
    {wbs_in, mm_in, wm_in, ni_in, wme_in} = ctl;
    sampleEdge = edgeCount + 1;
    if (rst) begin
      m = '{edgeNo: sampleEdge - 1, result: 16'h0, memData: 16'h0, regDest: 4'h0, ctl: 5'h0};
      if (mQ.size() > 0 && mQ[$].edgeNo == sampleEdge - 1) mQ[$] = m;
      else mQ.push_back(m);
      e = '{edgeNo: sampleEdge, srcB: 16'h0, exeValue: 16'h0, flagN: 1'b0, flagZ: 1'b1};
      m = '{edgeNo: sampleEdge, result: 16'h0, memData: 16'h0, regDest: 4'h0, ctl: 5'h0};
    end else begin
      e = '{edgeNo: sampleEdge, srcB: b, exeValue: expExe, flagN: expN, flagZ: expZ};
      m = '{edgeNo: sampleEdge, result: expRes, memData: expMem, regDest: rd, ctl: ctl};
    end
    eQ.push_back(e);
    mQ.push_back(m);
  endtask

  // E-stage values are checked after their sampling edge, M-stage one edge later.
  always @(negedge clk) begin
    while (eQ.size() > 0 && eQ[0].edgeNo <= edgeCount) begin
      eExp_t e;
      e = eQ.pop_front();
      if (e.edgeNo < edgeCount) begin
        checkCount++;
        failCount++;
        $display("[TB] FAIL e_stale: entry for edge %0d, now %0d", e.edgeNo, edgeCount);
      end else begin
        checkOutput("srcB_execute", srcB_execute, e.srcB);
        checkOutput("exe_value", exe_value, e.exeValue);
        checkOutput("flagN", {15'h0, flagN}, {15'h0, e.flagN});
        checkOutput("flagZ", {15'h0, flagZ}, {15'h0, e.flagZ});
      end
    end
    while (mQ.size() > 0 && mQ[0].edgeNo <= edgeCount - 1) begin
      mExp_t m;
      m = mQ.pop_front();
      if (m.edgeNo < edgeCount - 1) begin
        checkCount++;
        failCount++;
        $display("[TB] FAIL m_stale: entry for edge %0d, now %0d", m.edgeNo, edgeCount);
      end else begin
        checkOutput("alu_result_out", alu_result_out, m.result);
        checkOutput("mem_data_out", mem_data_out, m.memData);
        checkOutput("reg_dest_out", {12'h0, reg_dest_out}, {12'h0, m.regDest});
        checkOutput("ctl_out", {11'h0, wbs_out, mm_out, wm_out, ni_out, wme_out},
                    {11'h0, m.ctl});
      end
    end
  end

  initial begin
    reset = 1'b1;
    {wbs_in, mm_in, wm_in, ni_in, wme_in} = 5'h0;
    ALUop_in = 3'b000; am_in = 1'b0; alu_mux_in = 1'b0; alu_mux1_in = 1'b0;
    reg_dest_in = 4'h0; srcA_in = 16'h0; srcB_in = 16'h0;

    //            rst  op      A        B        am    mux   mux1  rd     ctl        res      mem      exe     N     Z
    applyStimulus(1'b1, 3'b000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0, 5'b00000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1);
    applyStimulus(1'b0, 3'b000, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 4'd5, 5'b10101, 16'h8000, 16'h0000, 16'h7FFF, 1'b1, 1'b0);
    applyStimulus(1'b0, 3'b001, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b1, 4'd6, 5'b01010, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1);
    applyStimulus(1'b0, 3'b001, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b1, 4'd7, 5'b11111, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b1, 1'b0);
    applyStimulus(1'b0, 3'b111, 16'h1111, 16'h00AB, 1'b1, 1'b1, 1'b1, 4'd8, 5'b00100, 16'h0000, 16'h00AB, 16'h0000, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'b010, 16'h1111, 16'h00AB, 1'b0, 1'b1, 1'b0, 4'd8, 5'b00010, 16'h00AB, 16'h0000, 16'h1111, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'b010, 16'hF0F0, 16'h0FF0, 1'b0, 1'b0, 1'b0, 4'd1, 5'b10000, 16'h00F0, 16'h0000, 16'hF0F0, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'b011, 16'hF000, 16'h000F, 1'b0, 1'b0, 1'b0, 4'd2, 5'b01000, 16'hF00F, 16'h0000, 16'hF000, 1'b1, 1'b0);
    applyStimulus(1'b0, 3'b100, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 4'd3, 5'b00001, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b1);
    applyStimulus(1'b0, 3'b101, 16'h8001, 16'h0004, 1'b0, 1'b0, 1'b1, 4'd4, 5'b10000, 16'h0010, 16'h0000, 16'h0010, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'b110, 16'h8001, 16'h0004, 1'b0, 1'b0, 1'b1, 4'd9, 5'b10000, 16'h0800, 16'h0000, 16'h0800, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'b101, 16'h8001, 16'h0014, 1'b0, 1'b0, 1'b0, 4'd10, 5'b00000, 16'h0010, 16'h0000, 16'h8001, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'b000, 16'hFFFF, 16'h0002, 1'b0, 1'b0, 1'b1, 4'd11, 5'b00001, 16'h0001, 16'h0000, 16'h0001, 1'b0, 1'b0);
    // Reset with live inputs: the write-enabled op in flight and these inputs are discarded.
    applyStimulus(1'b1, 3'b000, 16'h4444, 16'h5555, 1'b1, 1'b0, 1'b1, 4'd12, 5'b11111, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1);
    applyStimulus(1'b0, 3'b011, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd13, 5'b01001, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1);
    applyStimulus(1'b0, 3'b100, 16'hA5A5, 16'h0F0F, 1'b0, 1'b0, 1'b1, 4'd14, 5'b10010, 16'hAAAA, 16'h0000, 16'hAAAA, 1'b1, 1'b0);

    for (int i = 0; i < 20 && (eQ.size() > 0 || mQ.size() > 0); i++) @(negedge clk);
    #1;
    if (eQ.size() > 0 || mQ.size() > 0) begin
      checkCount++;
      failCount++;
      $display("[TB] FAIL drain: %0d E and %0d M entries left, expected 0", eQ.size(), mQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
